hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised ID-stage hazard unit for the pipelined MIPS core. It forwards operands for NREAD register read ports from the EX, MEM and WB result buses. It tracks in-flight loads in a small countdown scoreboard, so load-use and load write-after-write stalls work for any fixed load latency. It replaces the two-port, single-cycle-load forwarding/stall logic and drives the IF/ID stall and the ID operand muxes.

## Interface
- XLEN, 32: datapath width.
- NREAD, 2: number of register read ports.
- NPEND, 4: scoreboard entries, i.e. maximum loads in flight.
- LOAD_LAT, 3: cycles from load issue edge until the result sits on the WB bus; legal range 1..15.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NREAD*5  read-port register numbers; port i is bits [5i+4:5i].
- rd_data  in  NREAD*XLEN  register-file read values.
- id_valid  in  1  ID holds a real instruction.
- id_wreg, id_dest[4:0], id_is_load  in  ID instruction writes a register / destination / is a load.
- flush  in  1  ID instruction is being killed this cycle.
- ex_wreg, ex_dest[4:0], ex_result[XLEN-1:0]  in  EX-stage non-load result.
- mem_wreg, mem_destR[4:0], mem_aluR[XLEN-1:0]  in  MEM-stage result.
- wb_wreg, wb_destR[4:0], wb_dest[XLEN-1:0]  in  WB-stage result, including load data.
- fwd_data  out  NREAD*XLEN  forwarded operands.
- fwd_sel  out  NREAD*2  per-port source: 0 regfile, 1 WB, 2 MEM, 3 EX.
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- issue  out  1  id_valid & !stall & !flush.

## Operation
- Forwarding (combinational), per port:
  - Priority is EX > MEM > WB > regfile.
  - A source matches when its wreg=1, its dest is nonzero and its dest equals rd_addr.
  - Register 0 always reads rd_data with sel=0.
- Scoreboard entry fields: valid, dest[4:0], cnt[3:0].
- Allocation:
  - On an issue edge with id_is_load=1 and id_wreg=1, the lowest-index entry with valid=0 at the start of the cycle takes valid=1, dest=id_dest, cnt=LOAD_LAT.
  - A load to r0 does not allocate.
- Countdown:
  - Every edge, each valid entry decrements cnt.
  - An entry with cnt==1 clears valid at that edge.
  - The cycle with cnt==1 is the cycle the load data is on the WB bus.
- Stall when id_valid=1 and any of the following holds:
  - (a) Load-use: some valid entry with cnt>=2 and a nonzero dest equal to any rd_addr.
  - (b) Write-after-write: id_wreg=1 and some valid entry with cnt>=2 and dest==id_dest.
  - (c) Structural: id_is_load=1 and all NPEND entries are valid at the start of the cycle. An entry freeing at this edge does not count as free.
- flush=1 suppresses both issue and stall. A killed instruction never stalls or allocates.
- LOAD_LAT=1 never produces a load-use stall.

## Timing
- fwd_data, fwd_sel, stall and issue are combinational from the current inputs and scoreboard state. There are no output registers.
- Scoreboard state updates on the rising clk edge.
- Reset:
  - All entries are invalid and cnt=0.
  - While rst=1, stall=0, issue=0 and nothing allocates.
  - An rst mid-flight drops all pending loads; the pipeline is flushed by the same reset.
- With the default LOAD_LAT=3, a dependent instruction immediately after a load stalls exactly 2 cycles, then takes WB forwarding.
- A load and an unrelated instruction issue back-to-back without a bubble.

## Configuration
- HAZARD_STATS_EN defined: adds outputs stat_lu[31:0], stat_waw[31:0] and stat_full[31:0].
  - Each counts cycles in which the stall was caused by load-use, write-after-write or structural conditions respectively.
  - Priority for attribution is lu > waw > full.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- HAZARD_STATS_EN undefined: none of these ports or counters exist. Forwarding and stall behaviour is identical in both cases.

## Structure
- Package hazard_pkg holds:
  - REG_W=5.
  - Opcode constant OP_LW=6'b100011.
  - Typedef sb_entry_t (valid, dest, cnt).
  - Enum fwd_sel_t (SEL_RF, SEL_WB, SEL_MEM, SEL_EX).
- Sub-module load_scoreboard holds the entry array, allocation, countdown and match outputs (lu_hit, waw_hit, full).
- The top level instantiates load_scoreboard, plus forwarding muxes in a generate loop over NREAD.

## Test plan
- Priority: EX, MEM and WB all write r7 with 0x11/0x22/0x33, port0 reads r7 -> fwd_data0=0x11, sel=3. Reading r0 with all buses targeting r0 -> rd_data, sel=0.
- Load r5 issued, next instruction reads r5 (LOAD_LAT=3) -> stall=1 for 2 cycles, then issue with sel=1 and value = wb_dest.
- Four loads to r1..r4 issued back-to-back (NPEND=4), fifth load at cycle 4 -> stall exactly 1 cycle until entry 0 frees, then allocates entry 0.
- Load r9 pending, ALU instruction writing r9 and reading r2 -> WAW stall until cnt==1. Same instruction with flush=1 -> stall=0, no allocation.
- rst asserted while 3 loads are pending -> next cycle all entries invalid, and a dependent read does not stall.
- HAZARD_STATS_EN: run the load-use case twice -> stat_lu=4, stat_waw=0, stat_full=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the ID-stage hazard unit.
//   REG_W      register-number width
//   OP_LW      MIPS load-word opcode
//   sb_entry_t one in-flight load: valid, destination, cycles until WB
//   fwd_sel_t  operand source select encoding
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [5:0] OP_LW = 6'b100011;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic [3:0]       cnt;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SEL_RF  = 2'd0,
    SEL_WB  = 2'd1,
    SEL_MEM = 2'd2,
    SEL_EX  = 2'd3
  } fwd_sel_t;

endpackage

// File: rtl/load_scoreboard.sv
// load_scoreboard: countdown table of in-flight loads.
//   clk, rst   clock, synchronous active-high reset
//   rd_addr    NREAD packed read-port register numbers
//   id_dest    destination of the ID instruction
//   alloc      the ID load issues this edge and needs an entry
//   lu_hit     a read port depends on a load whose data is not yet on WB
//   waw_hit    id_dest matches a load whose data is not yet on WB
//   full       every entry is occupied at the start of the cycle
module load_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREAD    = 2,
  parameter int NPEND    = 4,
  parameter int LOAD_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*REG_W-1:0] rd_addr,
  input  logic [REG_W-1:0]       id_dest,
  input  logic                   alloc,
  output logic                   lu_hit,
  output logic                   waw_hit,
  output logic                   full
);

  localparam logic [3:0] LAT_CNT = 4'(LOAD_LAT);

  sb_entry_t        entries [NPEND];
  logic [NPEND-1:0] free_oh;
  logic             taken;

  // Lowest-index entry that is free at the start of the cycle; an entry
  // retiring this edge is still occupied here.
  always_comb begin
    free_oh = '0;
    taken   = 1'b0;
    for (int i = 0; i < NPEND; i++) begin
      if (!entries[i].valid && !taken) begin
        free_oh[i] = 1'b1;
        taken      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPEND; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].cnt   <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NPEND; i++) begin
        if (alloc && free_oh[i]) begin
          entries[i].valid <= 1'b1;
          entries[i].dest  <= id_dest;
          entries[i].cnt   <= LAT_CNT;
        end else if (entries[i].valid) begin
          entries[i].cnt <= entries[i].cnt - 4'd1;
          if (entries[i].cnt == 4'd1)
            entries[i].valid <= 1'b0;
        end
      end
    end
  end

  // cnt==1 means the data is on the WB bus and can be forwarded, so only
  // entries with cnt>=2 block.
  always_comb begin
    lu_hit  = 1'b0;
    waw_hit = 1'b0;
    full    = 1'b1;
    for (int i = 0; i < NPEND; i++) begin
      if (!entries[i].valid)
        full = 1'b0;
      if (entries[i].valid && entries[i].cnt >= 4'd2) begin
        if (entries[i].dest == id_dest)
          waw_hit = 1'b1;
        for (int p = 0; p < NREAD; p++) begin
          if (entries[i].dest != '0 && entries[i].dest == rd_addr[p*REG_W +: REG_W])
            lu_hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage operand forwarding and stall generation.
//   rd_addr/rd_data         NREAD register-file read ports
//   id_*                    ID-stage instruction attributes; flush kills it
//   ex_*/mem_*/wb_*         result buses (wb carries load data)
//   fwd_data/fwd_sel        per-port forwarded operand and its source
//   stall                   hold PC and IF/ID, bubble into EX
//   issue                   ID instruction advances this cycle
// Build option HAZARD_STATS_EN adds saturating stall-cause counters
//   stat_lu, stat_waw, stat_full (attribution priority lu > waw > full).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREAD    = 2,
  parameter int NPEND    = 4,
  parameter int LOAD_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*REG_W-1:0] rd_addr,
  input  logic [NREAD*XLEN-1:0]  rd_data,
  input  logic                   id_valid,
  input  logic                   id_wreg,
  input  logic [REG_W-1:0]       id_dest,
  input  logic                   id_is_load,
  input  logic                   flush,
  input  logic                   ex_wreg,
  input  logic [REG_W-1:0]       ex_dest,
  input  logic [XLEN-1:0]        ex_result,
  input  logic                   mem_wreg,
  input  logic [REG_W-1:0]       mem_destR,
  input  logic [XLEN-1:0]        mem_aluR,
  input  logic                   wb_wreg,
  input  logic [REG_W-1:0]       wb_destR,
  input  logic [XLEN-1:0]        wb_dest,
`ifdef HAZARD_STATS_EN
  output logic [31:0]            stat_lu,
  output logic [31:0]            stat_waw,
  output logic [31:0]            stat_full,
`endif
  output logic [NREAD*XLEN-1:0]  fwd_data,
  output logic [NREAD*2-1:0]     fwd_sel,
  output logic                   stall,
  output logic                   issue
);

  logic lu_hit, waw_hit, full;
  logic cause_lu, cause_waw, cause_full;
  logic alloc;

  load_scoreboard #(
    .NREAD    (NREAD),
    .NPEND    (NPEND),
    .LOAD_LAT (LOAD_LAT)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .id_dest (id_dest),
    .alloc   (alloc),
    .lu_hit  (lu_hit),
    .waw_hit (waw_hit),
    .full    (full)
  );

  assign cause_lu   = lu_hit;
  assign cause_waw  = id_wreg & waw_hit;
  assign cause_full = id_is_load & full;

  assign stall = !rst && !flush && id_valid && (cause_lu || cause_waw || cause_full);
  assign issue = !rst && !flush && id_valid && !stall;
  // Loads to r0 never occupy an entry.
  assign alloc = issue && id_is_load && id_wreg && (id_dest != '0);

  for (genvar p = 0; p < NREAD; p++) begin : g_fwd
    logic [REG_W-1:0] addr;
    logic [XLEN-1:0]  data;
    fwd_sel_t         sel;

    assign addr = rd_addr[p*REG_W +: REG_W];

    always_comb begin
      sel  = SEL_RF;
      data = rd_data[p*XLEN +: XLEN];
      if (addr != '0) begin
        if (ex_wreg && ex_dest == addr) begin
          sel  = SEL_EX;
          data = ex_result;
        end else if (mem_wreg && mem_destR == addr) begin
          sel  = SEL_MEM;
          data = mem_aluR;
        end else if (wb_wreg && wb_destR == addr) begin
          sel  = SEL_WB;
          data = wb_dest;
        end
      end
    end

    assign fwd_data[p*XLEN +: XLEN] = data;
    assign fwd_sel[p*2 +: 2]        = sel;
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lu   <= '0;
      stat_waw  <= '0;
      stat_full <= '0;
    end else if (stall) begin
      if (cause_lu) begin
        if (stat_lu != 32'hFFFF_FFFF) stat_lu <= stat_lu + 32'd1;
      end else if (cause_waw) begin
        if (stat_waw != 32'hFFFF_FFFF) stat_waw <= stat_waw + 32'd1;
      end else begin
        if (stat_full != 32'hFFFF_FFFF) stat_full <= stat_full + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        id_valid, id_wreg, id_is_load, flush;
  logic [4:0]  id_dest;
  logic        ex_wreg, mem_wreg, wb_wreg;
  logic [4:0]  ex_dest, mem_destR, wb_destR;
  logic [31:0] ex_result, mem_aluR, wb_dest;
  logic [63:0] fwd_data, fwd_data_b;
  logic [3:0]  fwd_sel, fwd_sel_b;
  logic        stall, issue, stall_b, issue_b;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_lu, stat_waw, stat_full;
  logic [31:0] stat_lu_b, stat_waw_b, stat_full_b;
`endif

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .id_valid(id_valid), .id_wreg(id_wreg), .id_dest(id_dest),
    .id_is_load(id_is_load), .flush(flush),
    .ex_wreg(ex_wreg), .ex_dest(ex_dest), .ex_result(ex_result),
    .mem_wreg(mem_wreg), .mem_destR(mem_destR), .mem_aluR(mem_aluR),
    .wb_wreg(wb_wreg), .wb_destR(wb_destR), .wb_dest(wb_dest),
`ifdef HAZARD_STATS_EN
    .stat_lu(stat_lu), .stat_waw(stat_waw), .stat_full(stat_full),
`endif
    .fwd_data(fwd_data), .fwd_sel(fwd_sel), .stall(stall), .issue(issue)
  );

  // Longer load latency so four back-to-back loads can fill the table.
  hazard_scoreboard #(.LOAD_LAT(4)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .id_valid(id_valid), .id_wreg(id_wreg), .id_dest(id_dest),
    .id_is_load(id_is_load), .flush(flush),
    .ex_wreg(ex_wreg), .ex_dest(ex_dest), .ex_result(ex_result),
    .mem_wreg(mem_wreg), .mem_destR(mem_destR), .mem_aluR(mem_aluR),
    .wb_wreg(wb_wreg), .wb_destR(wb_destR), .wb_dest(wb_dest),
`ifdef HAZARD_STATS_EN
    .stat_lu(stat_lu_b), .stat_waw(stat_waw_b), .stat_full(stat_full_b),
`endif
    .fwd_data(fwd_data_b), .fwd_sel(fwd_sel_b), .stall(stall_b), .issue(issue_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_wreg = 0; id_is_load = 0; id_dest = 0; flush = 0;
    rd_addr = 0; rd_data = {32'hDDDD_0001, 32'hDDDD_0000};
    ex_wreg = 0; ex_dest = 0; ex_result = 0;
    mem_wreg = 0; mem_destR = 0; mem_aluR = 0;
    wb_wreg = 0; wb_destR = 0; wb_dest = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic issue_load(input logic [4:0] d);
    idle();
    id_valid = 1; id_is_load = 1; id_wreg = 1; id_dest = d;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    id_valid = 1; id_is_load = 1; id_wreg = 1; id_dest = 5'd4; rd_addr = {5'd4, 5'd4};
    #1;
    vec++; if (stall !== 1'b0) begin miss++; $display("FAIL reset_stall: got %b want 0", stall); end
    vec++; if (issue !== 1'b0) begin miss++; $display("FAIL reset_issue: got %b want 0", issue); end
    tick();
    rst = 0;
    idle();
    id_valid = 1; rd_addr = {5'd4, 5'd4};
    #1;
    vec++; if (stall !== 1'b0) begin miss++; $display("FAIL reset_noalloc_stall: got %b want 0", stall); end
    vec++; if (issue !== 1'b1) begin miss++; $display("FAIL reset_after_issue: got %b want 1", issue); end
    vec++; if (fwd_sel !== 4'b0000) begin miss++; $display("FAIL reset_sel: got %h want 0", fwd_sel); end
    vec++; if (fwd_data !== 64'hDDDD_0001_DDDD_0000) begin miss++; $display("FAIL reset_data: got %h want DDDD0001DDDD0000", fwd_data); end
    tick();
    idle();
  endtask

  task automatic test_priority();
    idle();
    ex_wreg = 1;  ex_dest = 5'd7;   ex_result = 32'h11;
    mem_wreg = 1; mem_destR = 5'd7; mem_aluR = 32'h22;
    wb_wreg = 1;  wb_destR = 5'd7;  wb_dest = 32'h33;
    rd_addr = {5'd3, 5'd7};
    #1;
    vec++; if (fwd_sel[1:0] !== 2'd3 || fwd_data[31:0] !== 32'h11) begin miss++; $display("FAIL prio_ex: got sel %0d data %h want 3 11", fwd_sel[1:0], fwd_data[31:0]); end
    vec++; if (fwd_sel[3:2] !== 2'd0 || fwd_data[63:32] !== 32'hDDDD_0001) begin miss++; $display("FAIL prio_port1_rf: got sel %0d data %h want 0 DDDD0001", fwd_sel[3:2], fwd_data[63:32]); end
    ex_wreg = 0;
    #1;
    vec++; if (fwd_sel[1:0] !== 2'd2 || fwd_data[31:0] !== 32'h22) begin miss++; $display("FAIL prio_mem: got sel %0d data %h want 2 22", fwd_sel[1:0], fwd_data[31:0]); end
    mem_wreg = 0;
    #1;
    vec++; if (fwd_sel[1:0] !== 2'd1 || fwd_data[31:0] !== 32'h33) begin miss++; $display("FAIL prio_wb: got sel %0d data %h want 1 33", fwd_sel[1:0], fwd_data[31:0]); end
    ex_wreg = 1; ex_dest = 0; mem_wreg = 1; mem_destR = 0; wb_wreg = 1; wb_destR = 0;
    rd_addr = {5'd0, 5'd0};
    #1;
    vec++; if (fwd_sel !== 4'b0000 || fwd_data !== 64'hDDDD_0001_DDDD_0000) begin miss++; $display("FAIL prio_r0: got sel %h data %h want 0 DDDD0001DDDD0000", fwd_sel, fwd_data); end
    idle();
  endtask

  task automatic test_load_use();
    issue_load(5'd5);
    #1;
    vec++; if (issue !== 1'b1 || stall !== 1'b0) begin miss++; $display("FAIL lu_load_issue: got issue %b stall %b want 1 0", issue, stall); end
    tick();
    idle();
    id_valid = 1; id_wreg = 1; id_dest = 5'd6; rd_addr = {5'd0, 5'd5};
    for (int c = 1; c <= 2; c++) begin
      #1;
      vec++; if (stall !== 1'b1 || issue !== 1'b0) begin miss++; $display("FAIL lu_stall_c%0d: got stall %b issue %b want 1 0", c, stall, issue); end
      tick();
    end
    wb_wreg = 1; wb_destR = 5'd5; wb_dest = 32'hCAFE_F00D;
    #1;
    vec++; if (stall !== 1'b0 || issue !== 1'b1) begin miss++; $display("FAIL lu_release: got stall %b issue %b want 0 1", stall, issue); end
    vec++; if (fwd_sel[1:0] !== 2'd1 || fwd_data[31:0] !== 32'hCAFE_F00D) begin miss++; $display("FAIL lu_wb_fwd: got sel %0d data %h want 1 CAFEF00D", fwd_sel[1:0], fwd_data[31:0]); end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue_load(5'd6);
    #1;
    vec++; if (issue !== 1'b1) begin miss++; $display("FAIL b2b_load: got issue %b want 1", issue); end
    tick();
    idle();
    id_valid = 1; id_wreg = 1; id_dest = 5'd7; rd_addr = {5'd3, 5'd2};
    #1;
    vec++; if (issue !== 1'b1 || stall !== 1'b0) begin miss++; $display("FAIL b2b_alu: got issue %b stall %b want 1 0", issue, stall); end
    tick();
    issue_load(5'd8);
    #1;
    vec++; if (issue !== 1'b1) begin miss++; $display("FAIL b2b_load2: got issue %b want 1", issue); end
    tick();
    idle();
  endtask

  task automatic test_waw_flush();
    do_reset();
    issue_load(5'd9);
    tick();
    idle();
    id_valid = 1; id_wreg = 1; id_dest = 5'd9; rd_addr = {5'd0, 5'd2};
    #1;
    vec++; if (stall !== 1'b1) begin miss++; $display("FAIL waw_stall: got %b want 1", stall); end
    tick();
    flush = 1;
    #1;
    vec++; if (stall !== 1'b0 || issue !== 1'b0) begin miss++; $display("FAIL waw_flush: got stall %b issue %b want 0 0", stall, issue); end
    tick();
    flush = 0;
    #1;
    vec++; if (stall !== 1'b0 || issue !== 1'b1) begin miss++; $display("FAIL waw_release: got stall %b issue %b want 0 1", stall, issue); end
    tick();
    issue_load(5'd12);
    flush = 1;
    #1;
    vec++; if (issue !== 1'b0 || stall !== 1'b0) begin miss++; $display("FAIL flush_load: got issue %b stall %b want 0 0", issue, stall); end
    tick();
    idle();
    id_valid = 1; rd_addr = {5'd0, 5'd12};
    #1;
    vec++; if (stall !== 1'b0) begin miss++; $display("FAIL flush_noalloc: got stall %b want 0", stall); end
    tick();
    idle();
  endtask

  task automatic test_rst_midflight();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      issue_load(5'(i));
      #1;
      vec++; if (issue !== 1'b1) begin miss++; $display("FAIL mid_load%0d: got issue %b want 1", i, issue); end
      tick();
    end
    idle();
    id_valid = 1; rd_addr = {5'd0, 5'd2};
    #1;
    vec++; if (stall !== 1'b1) begin miss++; $display("FAIL mid_pre_rst_stall: got %b want 1", stall); end
    rst = 1;
    #1;
    vec++; if (stall !== 1'b0 || issue !== 1'b0) begin miss++; $display("FAIL mid_in_rst: got stall %b issue %b want 0 0", stall, issue); end
    tick();
    rst = 0;
    rd_addr = {5'd2, 5'd3};
    #1;
    vec++; if (stall !== 1'b0 || issue !== 1'b1) begin miss++; $display("FAIL mid_post_rst: got stall %b issue %b want 0 1", stall, issue); end
    tick();
    idle();
  endtask

  task automatic test_structural();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      issue_load(5'(i));
      #1;
      vec++; if (issue_b !== 1'b1) begin miss++; $display("FAIL full_load%0d: got issue %b want 1", i, issue_b); end
      tick();
    end
    issue_load(5'd5);
    #1;
    vec++; if (stall_b !== 1'b1 || issue_b !== 1'b0) begin miss++; $display("FAIL full_stall: got stall %b issue %b want 1 0", stall_b, issue_b); end
    tick();
    #1;
    vec++; if (stall_b !== 1'b0 || issue_b !== 1'b1) begin miss++; $display("FAIL full_release: got stall %b issue %b want 0 1", stall_b, issue_b); end
    tick();
    idle();
    id_valid = 1; rd_addr = {5'd0, 5'd5};
    #1;
    vec++; if (stall_b !== 1'b1) begin miss++; $display("FAIL full_alloc_dep: got stall %b want 1", stall_b); end
    tick();
    idle();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    do_reset();
    vec++; if (stat_lu !== 0 || stat_waw !== 0 || stat_full !== 0) begin miss++; $display("FAIL stats_reset: got %0d %0d %0d want 0 0 0", stat_lu, stat_waw, stat_full); end
    test_load_use();
    test_load_use();
    vec++; if (stat_lu !== 32'd4) begin miss++; $display("FAIL stats_lu: got %0d want 4", stat_lu); end
    vec++; if (stat_waw !== 32'd0 || stat_full !== 32'd0) begin miss++; $display("FAIL stats_other: got waw %0d full %0d want 0 0", stat_waw, stat_full); end
  endtask
`endif

  initial begin
    idle();
    rst = 1;
    tick();
    test_reset();
    test_priority();
    do_reset();
    test_load_use();
    test_back_to_back();
    test_waw_flush();
    test_rst_midflight();
    test_structural();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
